// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants and helpers for the VGA raster timing generator.
// Holds the default 640x480@60 timing (800x525 total raster) and a
// helper that returns the smallest counter width able to hold every
// x/y value for a given raster size.
package vga_timing_pkg;

  localparam int DEF_CW           = 13;
  localparam int DEF_H_TOTAL      = 800;
  localparam int DEF_H_SYNC_START = 2;
  localparam int DEF_H_SYNC_END   = 97;
  localparam int DEF_H_ACT_START  = 160;
  localparam int DEF_V_TOTAL      = 525;
  localparam int DEF_V_SYNC_START = 13;
  localparam int DEF_V_SYNC_END   = 14;
  localparam int DEF_V_ACT_START  = 45;
  localparam int DEF_HS_POL       = 0;
  localparam int DEF_VS_POL       = 0;
  localparam int DEF_REQ_LEAD     = 0;

  // Counters run 0..TOTAL-1, so clog2 of the larger total is enough bits.
  function automatic int min_cw(input int h_total, input int v_total);
    int span;
    span = (h_total > v_total) ? h_total : v_total;
    return (span <= 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis counter (used once for horizontal, once for vertical).
// Counts 0..MAX and wraps to 0 when enabled; a load overrides counting.
// count_next exposes the value the register takes at the next edge so the
// parent can register decoded outputs aligned with the counter.
// Ports:
//   clk, reset      pixel clock, synchronous active-high reset
//   en              advance by one (wrapping at MAX)
//   load            force count_next to load_value (takes priority over en)
//   load_value      value used by load
//   count           registered counter value
//   count_next      combinational next value
module vga_axis_counter #(
  parameter int W   = 13,
  parameter int MAX = 799
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE   = W'(1);

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_value;
    end else if (en) begin
      count_next = (count == MAX_V) ? '0 : count + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator. Owns the horizontal and
// vertical counters and derives sync, blanking, the pixel fetch request,
// active-area col/row and line/frame pulses. Every output is registered
// from the next-count values, so outputs always describe the x_count /
// y_count visible in the same cycle.
// Optional feature: define VGA_TIMING_GENLOCK_EN to add the ext_vs input;
// a rising edge on it (sampled on a pix_en cycle) forces the next counter
// state to x = 0, y = V_SYNC_START.
// Ports:
//   clk, reset              pixel clock, synchronous active-high reset
//   pix_en                  pixel strobe; nothing changes while low
//   x_count, y_count        raw counters
//   hs, vs                  syncs at HS_POL / VS_POL when asserted
//   blank_n                 high inside the active area
//   request                 pixel fetch request, REQ_LEAD pixels early
//   col, row                active coordinates, 0 outside the active area
//   line_start, frame_start one-strobe pulses at x = 0 / (x,y) = (0,0)
//   ext_vs                  genlock input (VGA_TIMING_GENLOCK_EN only)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW           = DEF_CW,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int H_ACT_START  = DEF_H_ACT_START,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END,
  parameter int V_ACT_START  = DEF_V_ACT_START,
  parameter int HS_POL       = DEF_HS_POL,
  parameter int VS_POL       = DEF_VS_POL,
  parameter int REQ_LEAD     = DEF_REQ_LEAD
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic [CW-1:0] x_count,
  output logic [CW-1:0] y_count,
  output logic          hs,
  output logic          vs,
  output logic          blank_n,
  output logic          request,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_GENLOCK_EN
  ,
  input  logic          ext_vs
`endif
);

  localparam logic [CW-1:0] H_MAX   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] HSS     = CW'(H_SYNC_START);
  localparam logic [CW-1:0] HSE     = CW'(H_SYNC_END);
  localparam logic [CW-1:0] HAS     = CW'(H_ACT_START);
  localparam logic [CW-1:0] VSS     = CW'(V_SYNC_START);
  localparam logic [CW-1:0] VSE     = CW'(V_SYNC_END);
  localparam logic [CW-1:0] VAS     = CW'(V_ACT_START);
  localparam logic [CW-1:0] REQ_ON  = CW'(H_ACT_START - REQ_LEAD);
  localparam logic [CW-1:0] REQ_OFF = CW'(H_TOTAL - REQ_LEAD);
  localparam logic          HS_ON   = (HS_POL != 0);
  localparam logic          VS_ON   = (VS_POL != 0);

  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;
  logic          h_wrap;
  logic          gl_fire;

  logic          hs_d;
  logic          vs_d;
  logic          blank_d;
  logic          req_d;
  logic [CW-1:0] col_d;
  logic [CW-1:0] row_d;
  logic          ls_d;
  logic          fs_d;

`ifdef VGA_TIMING_GENLOCK_EN
  logic ext_vs_q;

  // Edge register only advances on strobe cycles so a held-off pixel
  // clock cannot lose or double-count an ext_vs edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_vs_q <= 1'b0;
    end else if (pix_en) begin
      ext_vs_q <= ext_vs;
    end
  end

  // Suppressed when already sitting at the genlock point, otherwise the
  // line at V_SYNC_START would be replayed.
  assign gl_fire = pix_en && ext_vs && !ext_vs_q &&
                   !((x_count == '0) && (y_count == VSS));
`else
  assign gl_fire = 1'b0;
`endif

  assign h_wrap = pix_en && (x_count == H_MAX);

  vga_axis_counter #(
    .W   (CW),
    .MAX (H_TOTAL - 1)
  ) u_h_counter (
    .clk        (clk),
    .reset      (reset),
    .en         (pix_en),
    .load       (gl_fire),
    .load_value ('0),
    .count      (x_count),
    .count_next (x_next)
  );

  vga_axis_counter #(
    .W   (CW),
    .MAX (V_TOTAL - 1)
  ) u_v_counter (
    .clk        (clk),
    .reset      (reset),
    .en         (h_wrap),
    .load       (gl_fire),
    .load_value (VSS),
    .count      (y_count),
    .count_next (y_next)
  );

  // Decode from the next-count values so the registered outputs line up
  // with the counters with zero skew.
  always_comb begin
    hs_d    = ~HS_ON;
    vs_d    = ~VS_ON;
    blank_d = 1'b0;
    req_d   = 1'b0;
    col_d   = '0;
    row_d   = '0;
    ls_d    = 1'b0;
    fs_d    = 1'b0;

    if ((x_next >= HSS) && (x_next <= HSE)) begin
      hs_d = HS_ON;
    end
    if ((y_next >= VSS) && (y_next <= VSE)) begin
      vs_d = VS_ON;
    end

    blank_d = (x_next >= HAS) && (y_next >= VAS);

    // With no lead the window simply ends with the line; with a lead it
    // closes early so it never runs into the next line.
    if ((x_next >= REQ_ON) && (y_next >= VAS)) begin
      req_d = (REQ_LEAD == 0) ? 1'b1 : (x_next < REQ_OFF);
    end

    if (blank_d) begin
      col_d = x_next - HAS;
      row_d = y_next - VAS;
    end

    ls_d = (x_next == '0);
    fs_d = ls_d && (y_next == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs          <= ~HS_ON;
      vs          <= ~VS_ON;
      blank_n     <= 1'b0;
      request     <= 1'b0;
      col         <= '0;
      row         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hs          <= hs_d;
      vs          <= vs_d;
      blank_n     <= blank_d;
      request     <= req_d;
      col         <= col_d;
      row         <= row_d;
      line_start  <= ls_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Two instances: d0 with the default 800x525 raster, d1 with a small
// 20x12 raster (VS_POL = 1, REQ_LEAD = 2) so full frames fit in a short run.
// A behavioural raster model predicts each instance's outputs; predictions
// are queued when stimulus is driven and popped when outputs are sampled.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic [12:0] x;
    logic [12:0] y;
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic        request;
    logic [12:0] col;
    logic [12:0] row;
    logic        ls;
    logic        fs;
  } obs_t;

  typedef struct {
    int ht, hss, hse, has, vt, vss, vse, vas, lead;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    logic rst;
    logic en;
    int   ex;
    int   ey;
    logic ehs;
    logic evs;
    logic eblank;
    logic els;
    logic efs;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  logic ext_vs_tb = 1'b0;

  logic [12:0] d0_x, d0_y, d0_col, d0_row;
  logic        d0_hs, d0_vs, d0_blank, d0_req, d0_ls, d0_fs;
  logic [12:0] d1_x, d1_y, d1_col, d1_row;
  logic        d1_hs, d1_vs, d1_blank, d1_req, d1_ls, d1_fs;

  obs_t obs [2];
  obs_t sb_q0 [$];
  obs_t sb_q1 [$];

  cfg_t cfg [2];
  int   mx [2];
  int   my [2];
  logic mext [2];
  obs_t mexp [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen d0 (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .x_count     (d0_x),
    .y_count     (d0_y),
    .hs          (d0_hs),
    .vs          (d0_vs),
    .blank_n     (d0_blank),
    .request     (d0_req),
    .col         (d0_col),
    .row         (d0_row),
    .line_start  (d0_ls),
    .frame_start (d0_fs)
`ifdef VGA_TIMING_GENLOCK_EN
    ,
    .ext_vs      (1'b0)
`endif
  );

  vga_timing_gen #(
    .CW(13), .H_TOTAL(20), .H_SYNC_START(2), .H_SYNC_END(5), .H_ACT_START(8),
    .V_TOTAL(12), .V_SYNC_START(3), .V_SYNC_END(4), .V_ACT_START(6),
    .HS_POL(0), .VS_POL(1), .REQ_LEAD(2)
  ) d1 (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .x_count     (d1_x),
    .y_count     (d1_y),
    .hs          (d1_hs),
    .vs          (d1_vs),
    .blank_n     (d1_blank),
    .request     (d1_req),
    .col         (d1_col),
    .row         (d1_row),
    .line_start  (d1_ls),
    .frame_start (d1_fs)
`ifdef VGA_TIMING_GENLOCK_EN
    ,
    .ext_vs      (ext_vs_tb)
`endif
  );

  assign obs[0] = {d0_x, d0_y, d0_hs, d0_vs, d0_blank, d0_req, d0_col, d0_row, d0_ls, d0_fs};
  assign obs[1] = {d1_x, d1_y, d1_hs, d1_vs, d1_blank, d1_req, d1_col, d1_row, d1_ls, d1_fs};

  function automatic obs_t reset_obs(input cfg_t c);
    obs_t o;
    o = '0;
    o.hs = ~c.hpol;
    o.vs = ~c.vpol;
    return o;
  endfunction

  function automatic obs_t decode(input cfg_t c, input int x, input int y);
    obs_t o;
    o = '0;
    o.x       = 13'(x);
    o.y       = 13'(y);
    o.hs      = (x >= c.hss && x <= c.hse) ? c.hpol : ~c.hpol;
    o.vs      = (y >= c.vss && y <= c.vse) ? c.vpol : ~c.vpol;
    o.blank_n = (x >= c.has) && (y >= c.vas);
    o.request = (x >= c.has - c.lead) && (y >= c.vas) && (x < c.ht - c.lead);
    o.col     = o.blank_n ? 13'(x - c.has) : 13'd0;
    o.row     = o.blank_n ? 13'(y - c.vas) : 13'd0;
    o.ls      = (x == 0);
    o.fs      = (x == 0) && (y == 0);
    return o;
  endfunction

  task automatic model_step(input int k, input logic rst, input logic en, input logic ext);
    logic fire;
    if (rst) begin
      mx[k] = 0;
      my[k] = 0;
      mext[k] = 1'b0;
      mexp[k] = reset_obs(cfg[k]);
    end else if (en) begin
      fire = ext && !mext[k] && !(mx[k] == 0 && my[k] == cfg[k].vss);
`ifndef VGA_TIMING_GENLOCK_EN
      fire = 1'b0;
`endif
      mext[k] = ext;
      if (fire) begin
        mx[k] = 0;
        my[k] = cfg[k].vss;
      end else if (mx[k] == cfg[k].ht - 1) begin
        mx[k] = 0;
        my[k] = (my[k] == cfg[k].vt - 1) ? 0 : my[k] + 1;
      end else begin
        mx[k] = mx[k] + 1;
      end
      mexp[k] = decode(cfg[k], mx[k], my[k]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    obs_t e0, e1;
    e0 = sb_q0.pop_front();
    e1 = sb_q1.pop_front();
    n_cmp++;
    if (obs[0] !== e0) begin
      n_bad++;
      $display("[TB] FAIL d0_outputs @(%0d,%0d): got %h, expected %h", e0.x, e0.y, obs[0], e0);
    end
    n_cmp++;
    if (obs[1] !== e1) begin
      n_bad++;
      $display("[TB] FAIL d1_outputs @(%0d,%0d): got %h, expected %h", e1.x, e1.y, obs[1], e1);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic ext);
    reset = rst;
    pix_en = en;
    ext_vs_tb = ext;
    model_step(0, rst, en, 1'b0);
    model_step(1, rst, en, ext);
    sb_q0.push_back(mexp[0]);
    sb_q1.push_back(mexp[1]);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic run(input int n, input logic ext);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, ext);
  endtask

  vec_t vecs [8];

  initial begin
    cfg[0] = '{ht:800, hss:2, hse:97, has:160, vt:525, vss:13, vse:14, vas:45, lead:0, hpol:1'b0, vpol:1'b0};
    cfg[1] = '{ht:20, hss:2, hse:5, has:8, vt:12, vss:3, vse:4, vas:6, lead:2, hpol:1'b0, vpol:1'b1};
    $display("[TB] min counter width for default raster: %0d", min_cw(DEF_H_TOTAL, DEF_V_TOTAL));

    // Reset held three strobes, release, then a 1,0,0,1,1 strobe pattern.
    vecs[0] = '{rst:1, en:1, ex:0, ey:0, ehs:1, evs:1, eblank:0, els:0, efs:0};
    vecs[1] = '{rst:1, en:1, ex:0, ey:0, ehs:1, evs:1, eblank:0, els:0, efs:0};
    vecs[2] = '{rst:1, en:1, ex:0, ey:0, ehs:1, evs:1, eblank:0, els:0, efs:0};
    vecs[3] = '{rst:0, en:1, ex:1, ey:0, ehs:1, evs:1, eblank:0, els:0, efs:0};
    vecs[4] = '{rst:0, en:0, ex:1, ey:0, ehs:1, evs:1, eblank:0, els:0, efs:0};
    vecs[5] = '{rst:0, en:0, ex:1, ey:0, ehs:1, evs:1, eblank:0, els:0, efs:0};
    vecs[6] = '{rst:0, en:1, ex:2, ey:0, ehs:0, evs:1, eblank:0, els:0, efs:0};
    vecs[7] = '{rst:0, en:1, ex:3, ey:0, ehs:0, evs:1, eblank:0, els:0, efs:0};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, 1'b0);
      check_val($sformatf("vec%0d_x", i), int'(d0_x), vecs[i].ex);
      check_val($sformatf("vec%0d_y", i), int'(d0_y), vecs[i].ey);
      check_val($sformatf("vec%0d_hs", i), int'(d0_hs), int'(vecs[i].ehs));
      check_val($sformatf("vec%0d_vs", i), int'(d0_vs), int'(vecs[i].evs));
      check_val($sformatf("vec%0d_blank", i), int'(d0_blank), int'(vecs[i].eblank));
      check_val($sformatf("vec%0d_ls", i), int'(d0_ls), int'(vecs[i].els));
      check_val($sformatf("vec%0d_fs", i), int'(d0_fs), int'(vecs[i].efs));
    end

    // Free run d0 to the first active pixel (160,45); d1 wraps many frames meanwhile.
    run(45 * 800 + 160 - 3 - 1, 1'b0);
    check_val("d0_blank_before_active", int'(d0_blank), 0);
    run(1, 1'b0);
    check_val("d0_first_active_x", int'(d0_x), 160);
    check_val("d0_first_active_y", int'(d0_y), 45);
    check_val("d0_first_active_blank", int'(d0_blank), 1);
    check_val("d0_first_active_col", int'(d0_col), 0);
    check_val("d0_first_active_row", int'(d0_row), 0);

    // Reset mid-frame, then walk d1 through its request window and frame wrap.
    applyStimulus(1'b1, 1'b1, 1'b0);
    check_val("midframe_reset_x", int'(d0_x), 0);
    check_val("midframe_reset_req", int'(d1_req), 0);
    check_val("midframe_reset_ls", int'(d1_ls), 0);
    run(106, 1'b0);
    check_val("d1_req_line5_x6", int'(d1_req), 0);
    run(19, 1'b0);
    check_val("d1_req_x5_y6", int'(d1_req), 0);
    run(1, 1'b0);
    check_val("d1_req_rise_x6_y6", int'(d1_req), 1);
    run(11, 1'b0);
    check_val("d1_req_x17_y6", int'(d1_req), 1);
    run(1, 1'b0);
    check_val("d1_req_fall_x18_y6", int'(d1_req), 0);
    run(101, 1'b0);
    check_val("d1_last_col", int'(d1_col), 11);
    check_val("d1_last_row", int'(d1_row), 5);

    // Frame wrap with a 0,0,1,0,1 strobe pattern around it.
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    check_val("d1_hold_x", int'(d1_x), 19);
    check_val("d1_hold_fs", int'(d1_fs), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    check_val("d1_wrap_fs", int'(d1_fs), 1);
    check_val("d1_wrap_ls", int'(d1_ls), 1);
    check_val("d1_wrap_vs", int'(d1_vs), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    check_val("d1_wrap_fs_held", int'(d1_fs), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    check_val("d1_after_wrap_fs", int'(d1_fs), 0);
    check_val("d1_after_wrap_ls", int'(d1_ls), 0);

    // Random strobe pattern, checked by the scoreboard every cycle.
    for (int i = 0; i < 700; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);

`ifdef VGA_TIMING_GENLOCK_EN
    applyStimulus(1'b1, 1'b1, 1'b0);
    run(150, 1'b0);
    check_val("gl_pre_x", int'(d1_x), 10);
    run(1, 1'b1);
    check_val("gl_forced_x", int'(d1_x), 0);
    check_val("gl_forced_y", int'(d1_y), 3);
    check_val("gl_forced_vs", int'(d1_vs), 1);
    run(179, 1'b1);
    check_val("gl_no_early_fs", int'(d1_fs), 0);
    run(1, 1'b1);
    check_val("gl_frame_start", int'(d1_fs), 1);
    run(240, 1'b1);
    check_val("gl_period_fs", int'(d1_fs), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
